// File: rtl/fp32_add_pkg.sv
// fp32_add_pkg: shared types and constants for the FP32 adder controller.
// State encoding, rounding-mode codes and the default loop bound.
package fp32_add_pkg;

  localparam int DEF_MAX_STEPS = 24;

  localparam logic [1:0] RUP   = 2'b00;
  localparam logic [1:0] RDOWN = 2'b01;
  localparam logic [1:0] RTE   = 2'b10;
  localparam logic [1:0] RTAZ  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    RENORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp32_add_ctrl_if.sv
// fp32_add_ctrl_if: datapath flags in, stage enables and status out.
// master = datapath / requester side, slave = controller side.
interface fp32_add_ctrl_if;

  logic       start;
  logic [1:0] round_mode;
  logic       special;
  logic       align_done;
  logic       norm_done;
  logic       renorm;

  logic       ld_en;
  logic       align_en;
  logic       add_en;
  logic       norm_en;
  logic       round_en;
  logic       renorm_en;
  logic [1:0] rmode_q;
  logic       busy;
  logic       done;
  logic       ovf_step;

  modport master (
    output start, round_mode, special,
    output align_done, norm_done, renorm,
    input  ld_en, align_en, add_en, norm_en,
    input  round_en, renorm_en, rmode_q,
    input  busy, done, ovf_step
  );

  modport slave (
    input  start, round_mode, special,
    input  align_done, norm_done, renorm,
    output ld_en, align_en, add_en, norm_en,
    output round_en, renorm_en, rmode_q,
    output busy, done, ovf_step
  );

endinterface

// File: rtl/fp32_step_cnt.sv
// fp32_step_cnt: saturating iteration counter for the ALIGN/NORM loops.
// clr wins over en; sat is high once the count equals MAX.
module fp32_step_cnt #(
  parameter int MAX = 24,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sat
);

  logic [W-1:0] cnt;

  assign sat = (cnt == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fp32_add_ctrl.sv
// fp32_add_ctrl: sequencing FSM for a multi-cycle FP32 adder datapath.
// Stage enables are Moore-decoded; loop enables are gated by their done flag.
module fp32_add_ctrl
  import fp32_add_pkg::*;
#(
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input logic           clk,
  input logic           rst,
  fp32_add_ctrl_if.slave bus
);

  state_t     st;
  state_t     nxt;
  logic       sat;
  logic       clr;
  logic       step;
  logic       in_align;
  logic       in_norm;
  logic       align_go;
  logic       norm_go;

  logic       ld_q;
  logic       add_q;
  logic       round_q;
  logic       renorm_q;
  logic       busy_q;
  logic       done_q;
  logic       ovf_q;
  logic [1:0] rmode;

  assign in_align = (st == ALIGN);
  assign in_norm  = (st == NORM);

  // The exit cycle of each loop (done seen or bound hit) carries no enable.
  assign align_go = in_align && !bus.align_done && !sat;
  assign norm_go  = in_norm && !bus.norm_done && !sat;
  assign step     = align_go || norm_go;

  assign clr = ((nxt == ALIGN) && !in_align)
            || ((nxt == NORM) && !in_norm);

  fp32_step_cnt #(
    .MAX (MAX_STEPS)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (step),
    .sat (sat)
  );

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:   if (bus.start) nxt = LOAD;
      LOAD:   nxt = bus.special ? DONE : ALIGN;
      ALIGN:  if (bus.align_done || sat) nxt = ADD;
      ADD:    nxt = NORM;
      NORM:   if (bus.norm_done || sat) nxt = ROUND;
      ROUND:  nxt = bus.renorm ? RENORM : DONE;
      RENORM: nxt = DONE;
      DONE:   nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      ld_q     <= 1'b0;
      add_q    <= 1'b0;
      round_q  <= 1'b0;
      renorm_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rmode    <= RTE;
    end else begin
      st       <= nxt;
      ld_q     <= (nxt == LOAD);
      add_q    <= (nxt == ADD);
      round_q  <= (nxt == ROUND);
      renorm_q <= (nxt == RENORM);
      busy_q   <= (nxt != IDLE);
      done_q   <= (nxt == DONE);
      if ((st == IDLE) && bus.start) begin
        rmode <= bus.round_mode;
        ovf_q <= 1'b0;
      end else if ((in_align || in_norm) && sat) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign bus.ld_en     = ld_q;
  assign bus.align_en  = align_go;
  assign bus.add_en    = add_q;
  assign bus.norm_en   = norm_go;
  assign bus.round_en  = round_q;
  assign bus.renorm_en = renorm_q;
  assign bus.rmode_q   = rmode;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ovf_step  = ovf_q;

endmodule

// File: tb/tb_fp32_add_ctrl.sv
// tb_fp32_add_ctrl: directed bench with a toy datapath and scoreboard.
// Latency is counted with the LOAD cycle as cycle 1.
module tb_fp32_add_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp32_add_ctrl_if bus ();

  fp32_add_ctrl #(
    .MAX_STEPS (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int a_need = 0;
  int n_need = 0;
  int a_seen = 0;
  int n_seen = 0;
  int r_seen = 0;
  int add_seen = 0;
  int rnd_seen = 0;

  assign bus.align_done = (a_seen >= a_need);
  assign bus.norm_done  = (n_seen >= n_need);

  always @(posedge clk) begin
    if (bus.ld_en) begin
      a_seen   <= 0;
      n_seen   <= 0;
      r_seen   <= 0;
      add_seen <= 0;
      rnd_seen <= 0;
    end else begin
      if (bus.align_en)  a_seen   <= a_seen + 1;
      if (bus.norm_en)   n_seen   <= n_seen + 1;
      if (bus.renorm_en) r_seen   <= r_seen + 1;
      if (bus.add_en)    add_seen <= add_seen + 1;
      if (bus.round_en)  rnd_seen <= rnd_seen + 1;
    end
  end

  typedef struct {
    int         lat;
    logic [1:0] rm;
    logic       ovf;
    int         aen;
    int         nen;
    int         ren;
    int         add;
    int         rnd;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int clip(input int v);
    return (v > 24) ? 24 : v;
  endfunction

  task automatic run_txn(input string      tag,
                         input logic [1:0] rm,
                         input logic       sp,
                         input logic       rn,
                         input int         an,
                         input int         nn,
                         input bit         poke,
                         input bit         chain,
                         input logic [1:0] chain_rm);
    exp_t e;
    int   k;
    bit   got;
    a_need = an;
    n_need = nn;
    bus.special = sp;
    bus.renorm = rn;
    bus.start = 1'b1;
    bus.round_mode = rm;
    e.lat = sp ? 2 : 6 + clip(an) + clip(nn) + int'(rn);
    e.rm  = rm;
    e.ovf = !sp && (an >= 24 || nn >= 24);
    e.aen = sp ? 0 : clip(an);
    e.nen = sp ? 0 : clip(nn);
    e.ren = sp ? 0 : int'(rn);
    e.add = sp ? 0 : 1;
    e.rnd = sp ? 0 : 1;
    sbq.push_back(e);
    @(posedge clk);
    k = 1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 1);
    check({tag, "_ld"}, 32'(bus.ld_en), 1);
    check({tag, "_ovf_clr"}, 32'(bus.ovf_step), 0);
    check({tag, "_rmode_acc"}, 32'(bus.rmode_q), 32'(rm));
    got = 0;
    while (!got && k < 200) begin
      if (bus.done) begin
        got = 1;
      end else begin
        if (poke && bus.norm_en) begin
          bus.start = 1'b1;
          bus.round_mode = 2'b01;
          poke = 0;
        end
        @(posedge clk);
        k++;
        @(negedge clk);
        bus.start = 1'b0;
      end
    end
    e = sbq.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_lat"}, k, e.lat);
      check({tag, "_rmode"}, 32'(bus.rmode_q), 32'(e.rm));
      check({tag, "_ovf"}, 32'(bus.ovf_step), 32'(e.ovf));
      check({tag, "_aen"}, a_seen, e.aen);
      check({tag, "_nen"}, n_seen, e.nen);
      check({tag, "_ren"}, r_seen, e.ren);
      check({tag, "_add"}, add_seen, e.add);
      check({tag, "_rnd"}, rnd_seen, e.rnd);
    end
    if (chain) begin
      bus.start = 1'b1;
      bus.round_mode = chain_rm;
    end
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
    check({tag, "_idle"}, 32'(bus.busy), 0);
    check({tag, "_no_ld"}, 32'(bus.ld_en), 0);
    check({tag, "_ovf_hold"}, 32'(bus.ovf_step), 32'(e.ovf));
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.round_mode = 2'b00;
    bus.special = 1'b0;
    bus.renorm = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rmode", 32'(bus.rmode_q), 2);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_ovf", 32'(bus.ovf_step), 0);
    check("rst_en", 32'({bus.ld_en, bus.align_en, bus.add_en,
                         bus.norm_en, bus.round_en, bus.renorm_en}), 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn("normal", 2'b10, 1'b0, 1'b0, 3, 1, 0, 0, 2'b00);
    run_txn("renorm", 2'b00, 1'b0, 1'b1, 3, 1, 0, 0, 2'b00);
    run_txn("special", 2'b11, 1'b1, 1'b0, 3, 1, 0, 0, 2'b00);
    run_txn("a_ovf", 2'b10, 1'b0, 1'b0, 100, 0, 0, 1, 2'b01);
    run_txn("chained", 2'b01, 1'b0, 1'b0, 2, 2, 0, 0, 2'b00);
    run_txn("busy_poke", 2'b10, 1'b0, 1'b0, 1, 3, 1, 0, 2'b00);
    run_txn("n_ovf", 2'b11, 1'b0, 1'b0, 0, 100, 0, 0, 2'b00);

    a_need = 5;
    n_need = 1;
    bus.special = 1'b0;
    bus.renorm = 1'b0;
    bus.start = 1'b1;
    bus.round_mode = 2'b01;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_align_en", 32'(bus.align_en), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_align_off", 32'(bus.align_en), 0);
    check("mid_busy_off", 32'(bus.busy), 0);
    check("mid_rmode", 32'(bus.rmode_q), 2);
    check("mid_all_en", 32'({bus.ld_en, bus.add_en, bus.norm_en,
                             bus.round_en, bus.renorm_en, bus.done}), 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      seen |= bus.done;
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen |= bus.done;
    end
    check("mid_no_done", 32'(seen), 0);

    run_txn("post_rst", 2'b10, 1'b0, 1'b0, 0, 0, 0, 0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
